// File: rtl/bht_update_unit_pkg.sv
// Shared 2-bit branch predictor encoding and transition rule, used by both
// the lookup side and the write-back side of the branch history table.
package bht_update_unit_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    // S1 jumps straight to S3 on taken; S2 collapses to S0 on not-taken.
    function automatic logic [1:0] next_state(input logic [1:0] state, input logic taken);
        logic [1:0] result;
        case (state)
            S0:      result = taken ? S1 : S0;
            S1:      result = taken ? S3 : S0;
            S2:      result = taken ? S3 : S0;
            default: result = taken ? S3 : S2;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bht_pending_fifo.sv
// In-order queue of outstanding predictions. Stored counter states follow
// table writes to the same index so a later pop sees the freshest value.
module bht_pending_fifo
    import bht_update_unit_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [1:0]                   push_state,
    input  logic                         pop,
    input  logic                         fwd_en,
    input  logic [ADDR_W-1:0]            fwd_addr,
    input  logic [1:0]                   fwd_data,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [1:0]                   head_state,
    output logic                         head_dir,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [1:0]        state_mem [DEPTH];
    logic              dir_mem   [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Stale (unoccupied) slots may also pick up a forwarded state; that is
    // harmless because a push always rewrites the whole slot.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail == PW'(i)) begin
                addr_mem[i]  <= push_addr;
                dir_mem[i]   <= push_state[1];
                state_mem[i] <= (fwd_en && push_addr == fwd_addr) ? fwd_data : push_state;
            end else if (fwd_en && addr_mem[i] == fwd_addr) begin
                state_mem[i] <= fwd_data;
            end
        end
    end

    assign head_addr  = addr_mem[head];
    assign head_state = state_mem[head];
    assign head_dir   = dir_mem[head];
    assign count      = cnt;
    assign full       = (cnt == FULL_COUNT);
    assign empty      = (cnt == '0);

endmodule

// File: rtl/bht_update_unit.sv
// Write-back side of the branch history table: resolves queued predictions,
// computes the new counter state and drives the table write port.
module bht_update_unit
    import bht_update_unit_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         pred_valid,
    input  logic [ADDR_W-1:0]            pred_addr,
    input  logic [1:0]                   pred_state,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_ready,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [1:0]                   wr_data,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_addr;
    logic [1:0]        head_state;
    logic              head_dir;
    logic [1:0]        eff_state;

    assign pred_ready = !full;
    assign res_ready  = !empty;
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && res_ready;

    bht_pending_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_addr  (pred_addr),
        .push_state (pred_state),
        .pop        (pop),
        .fwd_en     (wr_en),
        .fwd_addr   (wr_addr),
        .fwd_data   (wr_data),
        .head_addr  (head_addr),
        .head_state (head_state),
        .head_dir   (head_dir),
        .count      (pending_count),
        .full       (full),
        .empty      (empty)
    );

    // The write leaving this cycle has not reached the queue yet, so a head
    // entry at the same index must see it directly.
    assign eff_state = (wr_en && wr_addr == head_addr) ? wr_data : head_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= S0;
            mispredict <= 1'b0;
        end else begin
            wr_en      <= pop;
            mispredict <= pop && (res_taken != head_dir);
            if (pop) begin
                wr_addr <= head_addr;
                wr_data <= next_state(eff_state, res_taken);
            end
        end
    end

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed test of bht_update_unit: expected writes go into a scoreboard queue
// and a negedge monitor compares them against each wr_en pulse.
module tb_bht_update_unit;
    import bht_update_unit_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        data;
        logic              mis;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_addr;
    logic [1:0]        pred_state;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic              res_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_data;
    logic              mispredict;
    logic [CW-1:0]     pending_count;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    bht_update_unit #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_addr     (pred_addr),
        .pred_state    (pred_state),
        .pred_ready    (pred_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_ready     (res_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .mispredict    (mispredict),
        .pending_count (pending_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus; ew marks that a table write is expected next cycle.
    task automatic apply_stimulus(input logic pv, input logic [ADDR_W-1:0] pa, input logic [1:0] ps,
                                  input logic rv, input logic rt,
                                  input logic ew, input logic [ADDR_W-1:0] ea, input logic [1:0] ed,
                                  input logic em);
        exp_t e;
        pred_valid = pv;
        pred_addr  = pa;
        pred_state = ps;
        res_valid  = rv;
        res_taken  = rt;
        if (ew) begin
            e.addr = ea;
            e.data = ed;
            e.mis  = em;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] pa, input logic [1:0] ps);
        apply_stimulus(1'b1, pa, ps, 1'b0, 1'b0, 1'b0, '0, S0, 1'b0);
    endtask

    task automatic pop(input logic rt, input logic [ADDR_W-1:0] ea, input logic [1:0] ed, input logic em);
        apply_stimulus(1'b0, '0, S0, 1'b1, rt, 1'b1, ea, ed, em);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, S0, 1'b0, 1'b0, 1'b0, '0, S0, 1'b0);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_wr_en", 32'(wr_en), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check_output("wr_data", 32'(wr_data), 32'(e.data));
                    check_output("mispredict", 32'(mispredict), 32'(e.mis));
                end
            end else if (mispredict) begin
                check_output("mispredict_without_wr_en", 32'(mispredict), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        pred_valid = 1'b0;
        pred_addr  = '0;
        pred_state = S0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_wr_en", 32'(wr_en), 32'd0);
        check_output("reset_wr_addr", 32'(wr_addr), 32'd0);
        check_output("reset_wr_data", 32'(wr_data), 32'(S0));
        check_output("reset_mispredict", 32'(mispredict), 32'd0);
        check_output("reset_count", 32'(pending_count), 32'd0);
        check_output("reset_pred_ready", 32'(pred_ready), 32'd1);
        check_output("reset_res_ready", 32'(res_ready), 32'd0);
        reset = 1'b0;
        idle(1);

        // Single push/resolve: S0 taken -> S1, predicted not-taken.
        push(10'h0F0, S0);
        check_output("single_count", 32'(pending_count), 32'd1);
        check_output("single_res_ready", 32'(res_ready), 32'd1);
        pop(1'b1, 10'h0F0, S1, 1'b1);
        check_output("single_count_after", 32'(pending_count), 32'd0);
        idle(2);

        // Fill, attempt overflow, then pop while pushing at full.
        push(10'h001, S0);
        push(10'h002, S1);
        push(10'h003, S2);
        push(10'h004, S3);
        check_output("full_pred_ready", 32'(pred_ready), 32'd0);
        push(10'h005, S0);
        check_output("full_count_hold", 32'(pending_count), 32'd4);
        apply_stimulus(1'b1, 10'h005, S0, 1'b1, 1'b1, 1'b1, 10'h001, S1, 1'b1);
        check_output("after_pop_count", 32'(pending_count), 32'd3);
        check_output("after_pop_pred_ready", 32'(pred_ready), 32'd1);
        pop(1'b0, 10'h002, S0, 1'b0);
        pop(1'b1, 10'h003, S3, 1'b0);
        pop(1'b0, 10'h004, S2, 1'b1);
        check_output("drain_count", 32'(pending_count), 32'd0);
        idle(2);

        // Same address S1/S1, taken twice: second pop uses the bypass.
        push(10'h0F0, S1);
        push(10'h0F0, S1);
        pop(1'b1, 10'h0F0, S3, 1'b1);
        pop(1'b1, 10'h0F0, S3, 1'b1);
        idle(2);

        // Same address S3/S3, not-taken twice: S2 then S0 via bypass.
        push(10'h0F0, S3);
        push(10'h0F0, S3);
        pop(1'b0, 10'h0F0, S2, 1'b1);
        pop(1'b0, 10'h0F0, S0, 1'b1);
        idle(2);

        // A push that coincides with a matching write takes the written state.
        push(10'h0F0, S0);
        push(10'h100, S0);
        pop(1'b1, 10'h0F0, S1, 1'b1);
        apply_stimulus(1'b1, 10'h0F0, S0, 1'b1, 1'b1, 1'b1, 10'h100, S1, 1'b1);
        check_output("fwd_push_count", 32'(pending_count), 32'd1);
        pop(1'b1, 10'h0F0, S3, 1'b1);
        idle(2);

        // Resolution with an empty queue must not write.
        check_output("empty_res_ready", 32'(res_ready), 32'd0);
        apply_stimulus(1'b0, '0, S0, 1'b1, 1'b1, 1'b0, '0, S0, 1'b0);
        check_output("empty_no_wr_en", 32'(wr_en), 32'd0);
        idle(1);

        // Simultaneous push and pop at count 2 keeps count and order.
        push(10'h010, S2);
        push(10'h020, S0);
        apply_stimulus(1'b1, 10'h030, S1, 1'b1, 1'b1, 1'b1, 10'h010, S3, 1'b0);
        check_output("pushpop_count", 32'(pending_count), 32'd2);
        pop(1'b0, 10'h020, S0, 1'b0);
        pop(1'b1, 10'h030, S3, 1'b1);
        idle(2);

        // Reset with three entries queued and a pop requested.
        push(10'h200, S0);
        push(10'h201, S1);
        push(10'h202, S2);
        reset     = 1'b1;
        res_valid = 1'b1;
        res_taken = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        res_valid = 1'b0;
        check_output("midreset_wr_en", 32'(wr_en), 32'd0);
        check_output("midreset_count", 32'(pending_count), 32'd0);
        check_output("midreset_res_ready", 32'(res_ready), 32'd0);
        check_output("midreset_pred_ready", 32'(pred_ready), 32'd1);
        idle(3);

        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
